inbuf_loader: RTL
=================

Name: inbuf_loader

Overview:
- Upstream sequencer for the PE-array input FIFO bank (one circular FIFO per lane, instantiated with PADDING=0).
- Accepts one tile of a matrix as a row-major valid/ready word stream and writes word j of every row into lane j.
- Writes the systolic skew itself: lane i is pre-filled with i zero words, so the FIFOs never need a reset between tiles.
- After loading, it issues a common read-strobe burst long enough to drain the most-skewed lane, then pulses done.

Parameters:
- WORDLEN, 8, data word width.
- LANES, 4, number of FIFO lanes / array rows fed (1..16).
- DEPTH, 8, maximum rows per tile; integrator guarantees DEPTH+LANES-1 <= FIFO BUFSIZE.
- CNTW, 5, width of the rows input and of the internal counters.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start  in  1  begin tile; sampled only in IDLE
- rows  in  CNTW  rows in the tile (K), latched on accepted start
- s_valid  in  1  stream word valid
- s_data  in  WORDLEN  stream word
- s_ready  out  1  loader accepts a word this cycle
- buf_write  out  LANES  per-lane FIFO write strobe
- buf_din  out  WORDLEN  shared FIFO write data
- buf_read  out  LANES  per-lane FIFO read strobe
- busy  out  1  tile in progress
- done  out  1  one-cycle pulse, tile drained
- err  out  1  one-cycle pulse, start rejected

Behaviour:
- All outputs are registered.
- On reset (rstn=0 at a clk edge):
  - State goes to IDLE, counters clear.
  - All outputs are 0 in the following cycle, including mid-tile; the partial tile is discarded.
  - The FIFOs share rstn and are cleared concurrently.
- IDLE:
  - start=1 with 1<=rows<=DEPTH: latch K=rows, go to PAD (or LOAD if LANES==1); busy=1 from the next cycle.
  - start=1 with rows=0 or rows>DEPTH: err=1 for one cycle; stay in IDLE.
- PAD: LANES-1 cycles, p=0..LANES-2.
  - buf_write bit i = (i > p); buf_din = 0.
  - Result: lane i receives exactly i zero words.
- LOAD: s_ready=1.
  - On each beat (s_valid && s_ready), the next cycle has buf_write = one-hot(col) and buf_din = s_data.
  - col wraps from LANES-1 to 0 and increments row.
  - The beat with row=K-1, col=LANES-1 is the last: s_ready=0 from the next cycle; go to SETTLE.
  - Gaps in s_valid only stall the load; no write is issued without a beat.
- SETTLE: 2 cycles, all strobes 0. This lets the last write land and the FIFO registered empty flags update.
- DRAIN: D = K+LANES-1 cycles.
  - buf_read = all ones.
  - Lane i holds K+i words and runs empty first; reads on an empty FIFO are harmless there, and it outputs 0.
- DONE: 1 cycle.
  - done=1, busy=1; then IDLE with busy=0.
- Outside LOAD, s_ready=0 and s_data is ignored.
- start is ignored while busy; no err is raised.
- Latency, no stalls: start edge to done = 1+(LANES-1)+K*LANES+1+2+D cycles.
  - The first +1 is the registered write after the last beat.
- Counters saturate-free: row < DEPTH <= 2^CNTW-1.
- No bufdat/FIFO full check: capacity is the integrator's guarantee.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with start=1, s_valid=1 -> all outputs 0, no write or read strobes.
- LANES=4, K=2, stream 1..8 with s_valid constant:
  - PAD masks 4'b1110, 4'b1100, 4'b1000 with buf_din=0.
  - Lane writes: lane0 {1,5}, lane1 {2,6}, lane2 {3,7}, lane3 {4,8}.
  - 2 idle cycles, then buf_read=4'b1111 for 5 cycles, then done pulse.
  - FIFO outputs form skewed diagonals: lane3 yields 0,0,0,4,8.
- Same tile with s_valid pattern 1,0,0,1,… -> writes appear exactly 1 cycle after each beat, data order unchanged, done delayed by the gap count only.
- Invalid rows:
  - start with rows=0 -> err pulse, busy stays 0.
  - start with rows=9 (DEPTH=8) -> err pulse, busy stays 0.
  - start while busy -> no effect, no err.
- rstn=0 during LOAD after 3 beats -> next cycle all outputs 0, state IDLE; a fresh start with K=1 completes correctly with lane i padding = i zeros.
- LANES=1, K=3, stream 7,8,9 -> no PAD cycles, writes 7,8,9, 3 drain reads, done at start+1+3+1+2+3 cycles.

Source files
------------

// File: rtl/inbuf_loader_if.sv
// Stream/strobe bundle between a tile source, the inbuf_loader and the lane FIFO bank.
// master: tile source side (drives start/rows/stream, observes status and strobes).
// slave : loader side (consumes start/rows/stream, drives ready, FIFO strobes and status).
interface inbuf_loader_if #(
  parameter int WORDLEN = 8,
  parameter int LANES   = 4,
  parameter int CNTW    = 5
);
  logic                start;
  logic [CNTW-1:0]     rows;
  logic                s_valid;
  logic [WORDLEN-1:0]  s_data;
  logic                s_ready;
  logic [LANES-1:0]    buf_write;
  logic [WORDLEN-1:0]  buf_din;
  logic [LANES-1:0]    buf_read;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, rows, s_valid, s_data,
    input  s_ready, buf_write, buf_din, buf_read, busy, done, err
  );

  modport slave (
    input  start, rows, s_valid, s_data,
    output s_ready, buf_write, buf_din, buf_read, busy, done, err
  );
endinterface

// File: rtl/inbuf_loader.sv
// Purpose: loads one row-major tile into per-lane FIFOs with systolic skew padding, then drains them.
// Latency: start to done = 1+(LANES-1)+K*LANES+1+2+(K+LANES-1) cycles plus stream stall cycles.
// Backpressure: s_ready high only while loading; s_valid gaps stall the load, no FIFO full check.
// Ports: clk/rstn (sync, active-low); bus.slave carries start/rows, the s_valid/s_ready/s_data
//        stream, buf_write/buf_din/buf_read FIFO strobes and busy/done/err status. All outputs registered.
module inbuf_loader #(
  parameter int WORDLEN = 8,
  parameter int LANES   = 4,
  parameter int DEPTH   = 8,
  parameter int CNTW    = 5
) (
  input  logic           clk,
  input  logic           rstn,
  inbuf_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAD, S_LOAD, S_SETTLE, S_DRAIN, S_DONE
  } state_t;

  localparam logic [CNTW-1:0] LASTCOL = CNTW'(LANES - 1);
  localparam logic [CNTW-1:0] PADLAST = CNTW'(LANES - 2);

  state_t              state, state_n;
  logic [CNTW-1:0]     cnt, cnt_n;   // pad index / settle count / drain count
  logic [CNTW-1:0]     row, row_n;
  logic [CNTW-1:0]     col, col_n;
  logic [CNTW-1:0]     k_q, k_n;

  logic                s_ready_q, s_ready_n;
  logic [LANES-1:0]    buf_write_q, buf_write_n;
  logic [WORDLEN-1:0]  buf_din_q, buf_din_n;
  logic [LANES-1:0]    buf_read_q, buf_read_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                err_q, err_n;
  logic                beat;

  assign beat = s_ready_q && bus.s_valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      row         <= '0;
      col         <= '0;
      k_q         <= '0;
      s_ready_q   <= 1'b0;
      buf_write_q <= '0;
      buf_din_q   <= '0;
      buf_read_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      row         <= row_n;
      col         <= col_n;
      k_q         <= k_n;
      s_ready_q   <= s_ready_n;
      buf_write_q <= buf_write_n;
      buf_din_q   <= buf_din_n;
      buf_read_q  <= buf_read_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      err_q       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    row_n       = row;
    col_n       = col;
    k_n         = k_q;
    s_ready_n   = 1'b0;
    buf_write_n = '0;
    buf_din_n   = '0;
    buf_read_n  = '0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.rows != '0 && bus.rows <= CNTW'(DEPTH)) begin
            k_n     = bus.rows;
            cnt_n   = '0;
            row_n   = '0;
            col_n   = '0;
            state_n = (LANES > 1) ? S_PAD : S_LOAD;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_PAD: begin
        if (cnt == PADLAST) begin
          cnt_n   = '0;
          state_n = S_LOAD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_LOAD: begin
        if (beat) begin
          // Write is registered, so it lands the cycle after the beat.
          buf_write_n = LANES'(1) << col;
          buf_din_n   = bus.s_data;
          if (col == LASTCOL) begin
            col_n = '0;
            if (row == k_q - 1'b1) begin
              cnt_n   = '0;
              state_n = S_SETTLE;
            end else begin
              row_n = row + 1'b1;
            end
          end else begin
            col_n = col + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        // Three cycles here: the first carries the final registered write,
        // the other two let it land and the FIFO empty flags catch up.
        if (cnt == CNTW'(2)) begin
          cnt_n   = '0;
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        // Most-skewed lane holds K+LANES-1 words.
        if (cnt == k_q + LASTCOL - 1'b1) begin
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Outputs are registered from the state being entered.
    busy_n    = (state_n != S_IDLE);
    s_ready_n = (state_n == S_LOAD);
    done_n    = (state_n == S_DONE);
    if (state_n == S_DRAIN) begin
      buf_read_n = '1;
    end
    if (state_n == S_PAD) begin
      // Pad step p writes a zero into every lane above p.
      for (int i = 0; i < LANES; i++) begin
        buf_write_n[i] = (CNTW'(i) > cnt_n);
      end
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.buf_write = buf_write_q;
  assign bus.buf_din   = buf_din_q;
  assign bus.buf_read  = buf_read_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
